// File: rtl/imem_boot_ctrl_if.sv
// Loader byte stream, core fetch port and instruction RAM port of the boot controller.
interface imem_boot_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload;
  logic [9:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        core_rst;
  logic        boot_err;

  modport slave (
    input  rx_valid, rx_data, reload, fetch_addr, mem_rdata,
    output rx_ready, fetch_data, fetch_valid, mem_we, mem_addr, mem_wdata,
           core_rst, boot_err
  );

  modport master (
    output rx_valid, rx_data, reload, fetch_addr, mem_rdata,
    input  rx_ready, fetch_data, fetch_valid, mem_we, mem_addr, mem_wdata,
           core_rst, boot_err
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot loader: receives a length-prefixed, XOR-checked byte image into instruction RAM,
// then releases the core and serves its fetches straight from that RAM.
module imem_boot_ctrl (
  input  logic              clk,
  input  logic              rst,
  imem_boot_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_len;
  logic [10:0] r_word_idx;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_xor;
  logic [23:0] r_asm;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_rx_ready;
  logic        r_core_rst;
  logic        r_boot_err;

  logic        w_accept;
  logic [15:0] w_len_full;
  logic        w_last_word;
  logic        w_loading_nxt;

  assign w_accept    = bus.rx_valid & r_rx_ready;
  assign w_len_full  = {bus.rx_data, r_len[7:0]};
  assign w_last_word = ({5'd0, r_word_idx} == (r_len - 16'd1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LEN0: if (w_accept) w_state_nxt = LEN1;
      LEN1: begin
        if (w_accept) begin
          if (w_len_full > 16'd1024)      w_state_nxt = ERR;
          else if (w_len_full == 16'd0)   w_state_nxt = CSUM;
          else                            w_state_nxt = DATA;
        end
      end
      DATA: if (w_accept && (r_byte_cnt == 2'd3) && w_last_word) w_state_nxt = CSUM;
      CSUM: if (w_accept) w_state_nxt = (bus.rx_data == r_xor) ? RUN : ERR;
      RUN:  if (bus.reload) w_state_nxt = LEN0;
      ERR:  if (bus.reload) w_state_nxt = LEN0;
      default: w_state_nxt = LEN0;
    endcase
  end

  assign w_loading_nxt = (w_state_nxt == LEN0) || (w_state_nxt == LEN1) ||
                         (w_state_nxt == DATA) || (w_state_nxt == CSUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LEN0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_xor      <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rx_ready <= 1'b1;
      r_core_rst <= 1'b1;
      r_boot_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= w_loading_nxt;
      r_core_rst <= (w_state_nxt != RUN);
      r_boot_err <= (w_state_nxt == ERR);
      r_we       <= 1'b0;
      // Address advances after its write pulse; a byte taken during the pulse starts the next word.
      if (r_we) r_word_idx <= r_word_idx + 11'd1;
      case (r_state)
        LEN0: if (w_accept) r_len[7:0] <= bus.rx_data;
        LEN1: begin
          if (w_accept) begin
            r_len[15:8] <= bus.rx_data;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
          end
        end
        DATA: begin
          if (w_accept) begin
            r_xor      <= r_xor ^ bus.rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_asm[7:0]   <= bus.rx_data;
              2'd1: r_asm[15:8]  <= bus.rx_data;
              2'd2: r_asm[23:16] <= bus.rx_data;
              default: begin
                r_we    <= 1'b1;
                r_wdata <= {bus.rx_data, r_asm};
              end
            endcase
          end
        end
        RUN, ERR: begin
          if (bus.reload) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_xor      <= '0;
            r_asm      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready    = r_rx_ready;
  assign bus.core_rst    = r_core_rst;
  assign bus.boot_err    = r_boot_err;
  assign bus.mem_we      = r_we;
  assign bus.mem_wdata   = r_wdata;
  assign bus.mem_addr    = (r_state == RUN) ? bus.fetch_addr : r_word_idx[9:0];
  assign bus.fetch_data  = (r_state == RUN) ? bus.mem_rdata : 32'h0000_0013;
  assign bus.fetch_valid = (r_state == RUN);

endmodule
